// File: rtl/ahb_dma_burst_reader.sv
// AHB-Lite read-DMA master: byte-length request -> pipelined INCR word reads, split at 1KB and BURST_MAX.
// Optional macro AHB_DMA_BYTE_MASK_EN adds o_rdata_be byte enables for a partial final word.
module ahb_dma_burst_reader #(
    parameter int ADDR_W    = 32,
    parameter int LEN_W     = 16,
    parameter int BURST_MAX = 16
) (
    input  logic              HCLK,
    input  logic              HRESET,
    input  logic              i_start,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [LEN_W-1:0]  i_len,
    output logic [ADDR_W-1:0] HADDR,
    output logic [1:0]        HTRANS,
    output logic [2:0]        HBURST,
    output logic [2:0]        HSIZE,
    output logic              HWRITE,
    input  logic [31:0]       HRDATA,
    input  logic              HREADY,
    input  logic              HRESP,
    output logic [31:0]       o_rdata,
    output logic              o_rdata_valid,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_error
`ifdef AHB_DMA_BYTE_MASK_EN
    ,
    output logic [3:0]        o_rdata_be
`endif
);

    localparam int CNT_W = LEN_W - 1;
    localparam int RUN_W = $clog2(BURST_MAX + 1);
    localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(BURST_MAX);

    localparam logic [1:0] TR_IDLE   = 2'b00;
    localparam logic [1:0] TR_NONSEQ = 2'b10;
    localparam logic [1:0] TR_SEQ    = 2'b11;

    typedef enum logic [1:0] {S_IDLE, S_XFER, S_ERR, S_DONE} state_t;

    state_t            state;
    logic [ADDR_W-1:0] addr_ptr;
    logic [CNT_W-1:0]  addr_left;
    logic [CNT_W-1:0]  data_left;
    logic [RUN_W-1:0]  run_cnt;
    logic              dphase_pend;
    logic [CNT_W-1:0]  words;
    logic              err_cut;
    logic              addr_active;
    logic              first_of_run;
    logic              addr_acc;
    logic              data_ok;
    logic              data_err;
    logic              unused_addr_lsb;
`ifdef AHB_DMA_BYTE_MASK_EN
    logic [1:0]        resid;
`endif

    assign words = CNT_W'(i_len[LEN_W-1:2]) + CNT_W'(|i_len[1:0]);
    assign unused_addr_lsb = ^i_addr[1:0];

    assign HADDR  = addr_ptr;
    assign HBURST = 3'b001;
    assign HSIZE  = 3'b010;
    assign HWRITE = 1'b0;

    // An ERROR response on the pending data phase cancels the next address in both response cycles.
    assign err_cut      = dphase_pend & HRESP;
    assign addr_active  = (state == S_XFER) && (addr_left != '0) && !err_cut;
    assign first_of_run = (run_cnt == '0) || (addr_ptr[9:0] == 10'd0) || (run_cnt == RUN_MAX);
    assign HTRANS       = addr_active ? (first_of_run ? TR_NONSEQ : TR_SEQ) : TR_IDLE;
    assign addr_acc     = addr_active & HREADY;
    assign data_ok      = (state == S_XFER) & dphase_pend & HREADY & ~HRESP;
    assign data_err     = (state == S_XFER) & dphase_pend & HREADY & HRESP;

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state         <= S_IDLE;
            addr_ptr      <= '0;
            addr_left     <= '0;
            data_left     <= '0;
            run_cnt       <= '0;
            dphase_pend   <= 1'b0;
            o_rdata       <= '0;
            o_rdata_valid <= 1'b0;
            o_busy        <= 1'b0;
            o_done        <= 1'b0;
            o_error       <= 1'b0;
`ifdef AHB_DMA_BYTE_MASK_EN
            resid         <= '0;
            o_rdata_be    <= '0;
`endif
        end else begin
            o_rdata_valid <= 1'b0;
            o_done        <= 1'b0;
            o_error       <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (i_start) begin
                        if (words != '0) begin
                            addr_ptr    <= {i_addr[ADDR_W-1:2], 2'b00};
                            addr_left   <= words;
                            data_left   <= words;
                            run_cnt     <= '0;
                            dphase_pend <= 1'b0;
                            o_busy      <= 1'b1;
                            state       <= S_XFER;
`ifdef AHB_DMA_BYTE_MASK_EN
                            resid       <= i_len[1:0];
`endif
                        end else begin
                            o_done <= 1'b1;
                            state  <= S_DONE;
                        end
                    end
                end
                S_XFER: begin
                    if (addr_acc) begin
                        addr_ptr  <= addr_ptr + ADDR_W'(4);
                        addr_left <= addr_left - CNT_W'(1);
                        run_cnt   <= first_of_run ? RUN_W'(1) : run_cnt + RUN_W'(1);
                    end
                    if (HREADY) begin
                        dphase_pend <= addr_acc;
                    end
                    if (data_err) begin
                        state <= S_ERR;
                    end else if (data_ok) begin
                        o_rdata       <= HRDATA;
                        o_rdata_valid <= 1'b1;
                        data_left     <= data_left - CNT_W'(1);
`ifdef AHB_DMA_BYTE_MASK_EN
                        if (data_left == CNT_W'(1) && resid != 2'd0) begin
                            o_rdata_be <= ~(4'hF << resid);
                        end else begin
                            o_rdata_be <= 4'hF;
                        end
`endif
                        if (data_left == CNT_W'(1)) begin
                            o_busy <= 1'b0;
                            o_done <= 1'b1;
                            state  <= S_DONE;
                        end
                    end
                end
                S_ERR: begin
                    o_busy  <= 1'b0;
                    o_done  <= 1'b1;
                    o_error <= 1'b1;
                    state   <= S_DONE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ahb_dma_burst_reader.sv
// Bench for ahb_dma_burst_reader: behavioural AHB slave plus a list-based reference of expected beats and words.
module tb_ahb_dma_burst_reader;

    localparam int AW = 32;
    localparam int LW = 16;
    localparam int BM = 4;

    logic          HCLK = 1'b0;
    logic          HRESET;
    logic          i_start;
    logic [AW-1:0] i_addr;
    logic [LW-1:0] i_len;
    logic [AW-1:0] HADDR;
    logic [1:0]    HTRANS;
    logic [2:0]    HBURST;
    logic [2:0]    HSIZE;
    logic          HWRITE;
    logic [31:0]   HRDATA;
    logic          HREADY;
    logic          HRESP;
    logic [31:0]   o_rdata;
    logic          o_rdata_valid;
    logic          o_busy;
    logic          o_done;
    logic          o_error;
`ifdef AHB_DMA_BYTE_MASK_EN
    logic [3:0]    o_rdata_be;
`endif

    always #5 HCLK = ~HCLK;

    ahb_dma_burst_reader #(.ADDR_W(AW), .LEN_W(LW), .BURST_MAX(BM)) dut (
        .HCLK(HCLK), .HRESET(HRESET), .i_start(i_start), .i_addr(i_addr), .i_len(i_len),
        .HADDR(HADDR), .HTRANS(HTRANS), .HBURST(HBURST), .HSIZE(HSIZE), .HWRITE(HWRITE),
        .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP),
        .o_rdata(o_rdata), .o_rdata_valid(o_rdata_valid), .o_busy(o_busy),
        .o_done(o_done), .o_error(o_error)
`ifdef AHB_DMA_BYTE_MASK_EN
        , .o_rdata_be(o_rdata_be)
`endif
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mem(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'h1234_5678;
    endfunction

    // wbeat/wn: wait states on a data beat; ebeat: beat answered with ERROR;
    // rcyc: cycle at which reset is asserted; poke: extra start pulse mid-transfer.
    task automatic run_xfer(input logic [31:0] addr, input int len, input int wbeat, input int wn,
                            input int ebeat, input int rcyc, input bit poke);
        logic [31:0] ea[$];
        logic [1:0]  et[$];
        logic [31:0] ed[$];
        logic [3:0]  eb[$];
        logic [31:0] ga[$];
        logic [1:0]  gt[$];
        logic [31:0] base, a, dp_a, p_a;
        logic [1:0]  p_tr;
        int n, last_ns, nacc, nval, res;
        int beat, dp_b, dp_c, done_n, done_cyc;
        bit exp_err, dp_v, pend, prev_wait;

        n = (len + 3) / 4;
        res = len % 4;
        base = addr & ~32'h3;
        last_ns = 0;
        for (int i = 0; i < n; i++) begin
            a = base + 32'(4 * i);
            ea.push_back(a);
            if (i == 0 || a[9:0] == 10'd0 || (i - last_ns) == BM) begin
                et.push_back(2'b10);
                last_ns = i;
            end else begin
                et.push_back(2'b11);
            end
        end
        exp_err = (ebeat > 0) && (ebeat <= n);
        nacc = exp_err ? ebeat : n;
        nval = exp_err ? ebeat - 1 : n;
        for (int i = 0; i < nval; i++) begin
            ed.push_back(mem(ea[i]));
            eb.push_back((i == n - 1 && res != 0) ? 4'((1 << res) - 1) : 4'hF);
        end

        i_addr  = addr;
        i_len   = 16'(len);
        i_start = 1'b1;
        @(posedge HCLK);
        #1;
        i_start = 1'b0;

        dp_v = 0; pend = 0; prev_wait = 0; beat = 0; dp_b = 0; dp_c = 0; dp_a = '0;
        done_n = 0; done_cyc = -1; p_tr = '0; p_a = '0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            if (rcyc > 0 && cyc == rcyc + 1) begin
                chk("rst_htrans", 32'(HTRANS), 32'd0);
                chk("rst_busy", 32'(o_busy), 32'd0);
                HRESET = 1'b0;
            end
            chk("valid_latency", 32'(o_rdata_valid), 32'(pend));
            if (o_rdata_valid) begin
                if (ed.size() > 0) begin
                    chk("rdata", o_rdata, ed.pop_front());
`ifdef AHB_DMA_BYTE_MASK_EN
                    chk("rdata_be", 32'(o_rdata_be), 32'(eb[0]));
`endif
                    void'(eb.pop_front());
                end else begin
                    chk("extra_valid", 32'(o_rdata_valid), 32'd0);
                end
            end
            if (o_done) begin
                done_n++;
                if (done_cyc < 0) done_cyc = cyc;
                chk("done_error", 32'(o_error), 32'(exp_err));
                chk("done_busy", 32'(o_busy), 32'd0);
            end
            if (cyc == 0) chk("busy_start", 32'(o_busy), 32'(n > 0));
            if (poke && cyc == 2) begin
                i_start = 1'b1; i_addr = 32'h0000_2000; i_len = 16'd8;
            end else if (poke && cyc == 3) begin
                i_start = 1'b0;
            end

            HRDATA = $urandom;
            if (dp_v) begin
                if (dp_b == ebeat) begin
                    HREADY = (dp_c >= 1); HRESP = 1'b1;
                end else if (dp_b == wbeat && dp_c < wn) begin
                    HREADY = 1'b0; HRESP = 1'b0;
                end else begin
                    HREADY = 1'b1; HRESP = 1'b0; HRDATA = mem(dp_a);
                end
            end else begin
                HREADY = 1'b1; HRESP = 1'b0;
            end
            #1;
            if (HTRANS == 2'b01) chk("no_busy_trans", 32'(HTRANS), 32'd0);
            if (prev_wait && !HRESP) begin
                chk("wait_htrans", 32'(HTRANS), 32'(p_tr));
                chk("wait_haddr", HADDR, p_a);
            end
            prev_wait = !HREADY && HTRANS[1] && !HRESP;
            p_tr = HTRANS;
            p_a = HADDR;
            pend = dp_v && HREADY && !HRESP;
            if (HREADY) begin
                if (HTRANS[1] && !(rcyc > 0 && cyc == rcyc)) begin
                    ga.push_back(HADDR); gt.push_back(HTRANS);
                    beat++; dp_v = 1; dp_a = HADDR; dp_b = beat; dp_c = 0;
                end else begin
                    dp_v = 0;
                end
            end else begin
                dp_c++;
            end
            if (rcyc > 0 && cyc == rcyc) begin
                HRESET = 1'b1; dp_v = 0; pend = 0;
            end
            if (rcyc > 0 && cyc >= rcyc + 6) break;
            if (rcyc == 0 && done_cyc >= 0 && cyc >= done_cyc + 2) break;
            @(posedge HCLK);
            #1;
        end

        if (rcyc == 0) begin
            chk("beat_count", 32'(ga.size()), 32'(nacc));
            chk("words_left", 32'(ed.size()), 32'd0);
            chk("done_count", 32'(done_n), 32'd1);
            if (n == 0) chk("zero_len_done_cyc", 32'(done_cyc), 32'd0);
        end else begin
            chk("rst_beats_bound", 32'(ga.size() <= n), 32'd1);
            chk("rst_no_done", 32'(done_n), 32'd0);
        end
        for (int i = 0; i < ga.size() && i < n; i++) begin
            chk($sformatf("haddr[%0d]", i), ga[i], ea[i]);
            chk($sformatf("htrans[%0d]", i), 32'(gt[i]), 32'(et[i]));
        end
        HREADY = 1'b1;
        HRESP  = 1'b0;
    endtask

    initial begin
        logic [31:0] ra;
        int rl, rn, we, wn, ee;

        HRESET = 1'b1; i_start = 1'b0; i_addr = '0; i_len = '0;
        HREADY = 1'b1; HRESP = 1'b0; HRDATA = '0;
        repeat (3) @(posedge HCLK);
        #1;
        chk("reset_haddr", HADDR, 32'd0);
        chk("reset_htrans", 32'(HTRANS), 32'd0);
        chk("reset_busy", 32'(o_busy), 32'd0);
        chk("reset_done", 32'(o_done), 32'd0);
        chk("reset_error", 32'(o_error), 32'd0);
        chk("reset_valid", 32'(o_rdata_valid), 32'd0);
        chk("reset_rdata", o_rdata, 32'd0);
        chk("hburst", 32'(HBURST), 32'd1);
        chk("hsize", 32'(HSIZE), 32'd2);
        chk("hwrite", 32'(HWRITE), 32'd0);
        HRESET = 1'b0;
        @(posedge HCLK);
        #1;

        run_xfer(32'h0000_1000, 16, 0, 0, 0, 0, 0);
        run_xfer(32'h0000_1100, 6, 0, 0, 0, 0, 0);
        run_xfer(32'h0000_13F8, 16, 0, 0, 0, 0, 0);
        run_xfer(32'h0000_1000, 40, 0, 0, 0, 0, 0);
        run_xfer(32'h0000_4000, 24, 2, 3, 0, 0, 0);
        run_xfer(32'h0000_3000, 32, 0, 0, 3, 0, 0);
        run_xfer(32'h0000_6001, 7, 0, 0, 0, 0, 0);
        run_xfer(32'hFFFF_FFF8, 16, 0, 0, 0, 0, 0);
        run_xfer(32'h0000_5000, 40, 0, 0, 0, 0, 1);
        run_xfer(32'h0000_7000, 0, 0, 0, 0, 0, 0);
        run_xfer(32'h0000_8000, 64, 0, 0, 0, 5, 0);
        run_xfer(32'h0000_9000, 12, 0, 0, 1, 0, 0);

        for (int k = 0; k < 12; k++) begin
            ra = $urandom;
            if (k % 2 == 0) ra[9:0] = 10'h3FF - 10'($urandom_range(0, 60));
            rl = $urandom_range(1, 120);
            rn = (rl + 3) / 4;
            we = $urandom_range(1, rn);
            wn = $urandom_range(0, 3);
            ee = ($urandom_range(0, 3) == 0) ? $urandom_range(1, rn) : 0;
            run_xfer(ra, rl, we, wn, ee, 0, 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ahb_dma_burst_reader.md
Name: ahb_dma_burst_reader

Overview:
- Parametrised AHB-Lite read-DMA master, successor to the single-channel core-system DMA master.
- Converts a byte-length/start-address request into word reads: pipelined INCR bursts, wait-state tolerant, with 1KB-boundary and max-burst splitting.
- Streams read words out with a valid strobe, handles ERROR responses, and reports completion status.
- Sits between the CPU register block (address/length/start) and the AHB-Lite interconnect.

Parameters:
- ADDR_W, 32, HADDR width.
- LEN_W, 16, byte-length field width.
- BURST_MAX, 16, max beats per NONSEQ-started run (power of 2, 1..256).

Ports:
- HCLK  in  1  clock.
- HRESET  in  1  synchronous, active-high reset.
- i_start  in  1  start pulse; sampled only in IDLE.
- i_addr  in  ADDR_W  start byte address; bits[1:0] ignored (forced 0).
- i_len  in  LEN_W  transfer length in bytes.
- HADDR  out  ADDR_W  bus address.
- HTRANS  out  2  IDLE=0, BUSY=1, NONSEQ=2, SEQ=3.
- HBURST  out  3  constant INCR (3'b001).
- HSIZE  out  3  constant WORD (3'b010).
- HWRITE  out  1  constant 0 (read).
- HRDATA  in  32  read data.
- HREADY  in  1  transfer done / wait.
- HRESP  in  1  0=OKAY, 1=ERROR.
- o_rdata  out  32  captured read word.
- o_rdata_valid  out  1  one-cycle strobe per good beat.
- o_busy  out  1  high from accepted start until o_done.
- o_done  out  1  one-cycle completion pulse.
- o_error  out  1  valid with o_done; 1 = aborted by ERROR.

Behaviour:
- Reset (HRESET=1 at HCLK edge): state IDLE. HADDR=0, HTRANS=IDLE, o_rdata=0, o_rdata_valid=0, o_busy=0, o_done=0, o_error=0, all counters 0. Reset mid-transfer aborts immediately; no o_done.
- Word count: WORDS = ceil(i_len/4) = (i_len>>2) + (|i_len[1:0]), width LEN_W-1 bits.
- States: IDLE, XFER, ERR, DONE.
- IDLE:
  - i_start=1 and WORDS>0: latch addr_ptr={i_addr[ADDR_W-1:2],2'b00}; addr_left=WORDS; data_left=WORDS; run_cnt=0; go XFER.
  - i_start=1 and WORDS=0: go DONE; no bus activity.
  - i_start while not IDLE: ignored.
- XFER, address side:
  - HADDR=addr_ptr.
  - HTRANS=IDLE when addr_left=0.
  - HTRANS=NONSEQ for the first beat, when addr_ptr[9:0]=0, or when run_cnt=BURST_MAX; otherwise SEQ.
  - On HREADY=1 with HTRANS active: addr_ptr+=4, addr_left-=1, set dphase_pend; run_cnt=1 after NONSEQ, else run_cnt+1.
  - HREADY=0: HADDR/HTRANS hold stable. BUSY is never driven.
- XFER, data side:
  - On HREADY=1 with dphase_pend and HRESP=OKAY: o_rdata<=HRDATA, o_rdata_valid<=1 (registered, 1-cycle latency), data_left-=1. dphase_pend clears unless a new address was accepted in the same cycle.
  - When data_left reaches 0: go DONE.
- Error handling:
  - HRESP=ERROR with HREADY=0 (first error cycle): HTRANS forced IDLE combinationally that cycle.
  - Next edge with HREADY=1, HRESP=ERROR: go ERR. No valid strobe for the errored beat. Remaining addresses are never issued.
- ERR: one cycle, HTRANS=IDLE; go DONE with the error flag set.
- DONE: o_done=1 for one cycle; o_error=1 only if entered via ERR; o_busy drops the same cycle; return to IDLE.
- o_busy=1 in XFER and ERR.
- Address wraps modulo 2^ADDR_W; no special handling.

Optional Feature:
- Macro: AHB_DMA_BYTE_MASK_EN.
- Defined: adds output o_rdata_be[3:0], valid with o_rdata_valid. It is 4'b1111 except on the final word of a transfer with i_len[1:0]!=0, where it is 4'b0001, 4'b0011 or 4'b0111 for residues 1, 2 or 3.
- Undefined: port absent; all words are treated as full.

Test Plan:
- i_addr=0x1000, i_len=16, HREADY=1 always -> HTRANS NONSEQ,SEQ,SEQ,IDLE-after-4 on HADDR 0x1000/04/08/0C; 4 valid strobes, each 1 cycle after its data phase; o_done 1 pulse, o_error=0.
- i_len=6 -> WORDS=2, two beats; with AHB_DMA_BYTE_MASK_EN, second o_rdata_be=4'b0011.
- i_addr=0x13F8, i_len=16 -> NONSEQ at 0x13F8, SEQ 0x13FC, NONSEQ at 0x1400, SEQ 0x1404.
- BURST_MAX=4, i_len=40 -> NONSEQ at beats 1, 5 and 9; 10 valid strobes total.
- HREADY low 3 cycles on beat 2 -> HADDR/HTRANS stable throughout; data captured only on the HREADY-high edge; total beats unchanged.
- ERROR on beat 3 of 8 -> HTRANS IDLE in the first error cycle; exactly 2 valid strobes; o_done with o_error=1; no address beyond beat 4 issued. Also: HRESET mid-burst -> HTRANS IDLE and o_busy=0 the next cycle, no o_done. Also: i_len=0 -> o_done after 1 cycle with no bus activity.
